valu_seq: RTL and testbench
===========================

# valu_seq

Vector element sequencer on the issue side of the VALU lane interface. Accepts one vector ALU instruction at a time. Walks the vector in groups of VECTOR_LANES elements: reads operands from the VRF, drives one VALU per lane with per-lane valid/mask, then registers the lane results into a masked writeback beat. Sits between the vector issue queue and the VALU lane array / VRF write port.

## Interface
- DATA_WIDTH, 32, element width
- MICROOP_WIDTH, 5, VALU microop width
- VECTOR_LANES, 8, lanes per group (power of 2)
- VLW, $clog2(32*VECTOR_LANES)+1, vl width; max VL = 32*VECTOR_LANES
- GW, 5, group index width (32 groups max)
- clk  in  1  clock; all logic rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid_i  in  1  instruction offered
- issue_ready_o  out  1  high only in IDLE
- issue_microop_i  in  MICROOP_WIDTH  VALU encoding
- issue_vl_i  in  VLW  element count
- issue_vm_i  in  1  1 = unmasked, 0 = use issue_mask_i
- issue_mask_i  in  32*VECTOR_LANES  per-element mask
- issue_imm_i  in  DATA_WIDTH  immediate, broadcast to all lanes
- rd_req_o  out  1  VRF group read; data valid exactly 1 cycle later
- rd_grp_o  out  GW  group index
- rd_data_a_i, rd_data_b_i  in  VECTOR_LANES*DATA_WIDTH  operands, lane 0 in LSBs
- valu_valid_o  out  VECTOR_LANES  per-lane VALU valid
- valu_data_a_o, valu_data_b_o  out  VECTOR_LANES*DATA_WIDTH  lane operands
- valu_imm_o  out  DATA_WIDTH; valu_microop_o  out  MICROOP_WIDTH; valu_vl_o  out  VLW
- valu_mask_o  out  VECTOR_LANES  per-lane mask bit
- valu_ready_res_i  in  VECTOR_LANES; valu_result_i  in  VECTOR_LANES*DATA_WIDTH  (combinational, same cycle)
- wb_valid_o  out  1; wb_ready_i  in  1; wb_grp_o  out  GW
- wb_data_o  out  VECTOR_LANES*DATA_WIDTH; wb_en_o  out  VECTOR_LANES  lane write enable
- done_o  out  1  one-cycle completion pulse; done_err_o  out  1  valid with done_o

## Operation
- FSM: IDLE, READ, EXEC, WB, DONE.
- IDLE: latch microop, imm, vm, mask, vl. Latched vl = min(issue_vl_i, 32*VECTOR_LANES). Clear err and grp. vl=0 -> DONE; else -> READ.
- READ: rd_req_o=1, rd_grp_o=grp -> EXEC.
- EXEC: lane i active iff e = grp*VECTOR_LANES+i satisfies e < vl and (vm or mask[e]). valu_valid_o = active; valu_mask_o[i] = vm | mask[e]. Register result lane i = active ? valu_result_i[i] : 0 into wb_data. wb_en[i] = active & valu_ready_res_i[i]. Any active lane with valu_ready_res_i low sets err (sticky). -> WB.
- WB: wb_valid_o=1, hold data/grp/en stable until wb_ready_i. On handshake: grp+1; if (grp+1)*VECTOR_LANES >= vl -> DONE, else READ.
- DONE: done_o=1, done_err_o=err -> IDLE.
- valu_* data/microop/imm/vl are driven from latched/VRF values in all states; valu_valid_o is 0 outside EXEC.

## Timing
- Reset: state IDLE; issue_ready_o=1; all other outputs 0; err=0; grp=0.
- Reset mid-operation: abort with no further rd_req, wb or done_o. IDLE next cycle.
- Accept at cycle 0. READ c1, EXEC c2, WB c3. With wb_ready_i=1: 3 cycles per group; DONE at c(3N+1) for N groups.
- vl=0: DONE at c1, no reads.
- No overlap between groups; issue_ready_o=0 from c1 until the cycle after DONE.

## Structure
- Shared package valu_pkg: microop localparams (VADD=5'b00001 … VSRAI=5'b11000), state enum, VLW/GW constants.
- Sub-module valu_seq_laneen: combinational active-lane and mask vector from grp, vl, vm, mask.

## Test plan
- VADD, vl=8, vm=1, A lane i = i, B = 10 -> rd_req c1 grp0; wb c3 data 10..17, wb_en=0xFF; done_o c4, done_err_o=0.
- VSUB, vl=11 -> wb grp0 c3 wb_en=0xFF; wb grp1 c6 wb_en=0x07, lanes 3-7 data 0; done c7.
- VAND, vl=8, vm=0, mask=0xA5 -> valu_valid_o=0xA5, wb_en=0xA5, masked lanes data 0.
- wb_ready_i low c3-c5 -> wb_valid/data/grp held; no rd_req until handshake c6; next READ c7.
- microop 5'b01111, vl=8 -> wb_en=0x00; done_o with done_err_o=1.
- vl=0 -> no rd_req, done c1. rst during EXEC -> IDLE next cycle, issue_ready_o=1, no wb_valid.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared constants, VALU microop encodings and sequencer state type for the
// vector element sequencer.
package valu_pkg;

  localparam int VALU_DATA_WIDTH    = 32;
  localparam int VALU_MICROOP_WIDTH = 5;
  localparam int VALU_LANES         = 8;
  localparam int VALU_MAX_VL        = 32 * VALU_LANES;
  localparam int VALU_VLW           = $clog2(VALU_MAX_VL) + 1;
  localparam int VALU_GW            = 5;

  // Register-register microops
  localparam logic [VALU_MICROOP_WIDTH-1:0] VADD  = 5'b00001;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VSUB  = 5'b00010;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VAND  = 5'b00011;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VOR   = 5'b00100;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VXOR  = 5'b00101;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VSLL  = 5'b00110;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VSRL  = 5'b00111;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VSRA  = 5'b01000;
  // Register-immediate microops
  localparam logic [VALU_MICROOP_WIDTH-1:0] VADDI = 5'b10001;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VANDI = 5'b10011;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VORI  = 5'b10100;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VXORI = 5'b10101;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VSLLI = 5'b10110;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VSRLI = 5'b10111;
  localparam logic [VALU_MICROOP_WIDTH-1:0] VSRAI = 5'b11000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/valu_seq_laneen.sv
// Per-lane activity and mask for the current element group. Element index of
// lane i is grp*VECTOR_LANES + i; a lane is active when that element lies
// inside vl and is either unmasked or enabled by the mask vector.
module valu_seq_laneen
  import valu_pkg::*;
#(
  parameter int VECTOR_LANES = VALU_LANES,
  parameter int VLW          = VALU_VLW,
  parameter int GW           = VALU_GW
) (
  input  logic [GW-1:0]             grp_i,
  input  logic [VLW-1:0]            vl_i,
  input  logic                      vm_i,
  input  logic [32*VECTOR_LANES-1:0] mask_i,
  output logic [VECTOR_LANES-1:0]   active_o,
  output logic [VECTOR_LANES-1:0]   mask_o
);

  localparam int LW = $clog2(VECTOR_LANES);
  localparam int EW = GW + LW;
  localparam int CW = ((EW > VLW) ? EW : VLW) + 1;

  logic [EW-1:0] elem;
  logic          laneOn;

  // Evaluate every lane of the group against vl and the element mask
  always_comb begin
    active_o = '0;
    mask_o   = '0;
    elem     = '0;
    laneOn   = 1'b0;
    for (int i = 0; i < VECTOR_LANES; i++) begin
      elem        = {grp_i, LW'(i)};
      laneOn      = vm_i | mask_i[elem];
      mask_o[i]   = laneOn;
      active_o[i] = (CW'(elem) < CW'(vl_i)) & laneOn;
    end
  end

endmodule

// File: rtl/valu_seq.sv
// Vector element sequencer: accepts one VALU instruction, walks it in groups
// of VECTOR_LANES elements (VRF read, lane execute, masked writeback beat)
// and pulses done_o with a sticky error flag when the last group retires.
module valu_seq
  import valu_pkg::*;
#(
  parameter int DATA_WIDTH    = VALU_DATA_WIDTH,
  parameter int MICROOP_WIDTH = VALU_MICROOP_WIDTH,
  parameter int VECTOR_LANES  = VALU_LANES,
  parameter int VLW           = $clog2(32*VECTOR_LANES) + 1,
  parameter int GW            = VALU_GW
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  logic [MICROOP_WIDTH-1:0]           issue_microop_i,
  input  logic [VLW-1:0]                     issue_vl_i,
  input  logic                               issue_vm_i,
  input  logic [32*VECTOR_LANES-1:0]         issue_mask_i,
  input  logic [DATA_WIDTH-1:0]              issue_imm_i,
  output logic                               rd_req_o,
  output logic [GW-1:0]                      rd_grp_o,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] rd_data_a_i,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] rd_data_b_i,
  output logic [VECTOR_LANES-1:0]            valu_valid_o,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] valu_data_a_o,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] valu_data_b_o,
  output logic [DATA_WIDTH-1:0]              valu_imm_o,
  output logic [MICROOP_WIDTH-1:0]           valu_microop_o,
  output logic [VLW-1:0]                     valu_vl_o,
  output logic [VECTOR_LANES-1:0]            valu_mask_o,
  input  logic [VECTOR_LANES-1:0]            valu_ready_res_i,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] valu_result_i,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [GW-1:0]                      wb_grp_o,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] wb_data_o,
  output logic [VECTOR_LANES-1:0]            wb_en_o,
  output logic                               done_o,
  output logic                               done_err_o
);

  localparam int LW     = $clog2(VECTOR_LANES);
  localparam int MAX_VL = 32 * VECTOR_LANES;
  localparam int CW     = ((GW + 1 + LW) > VLW) ? (GW + 1 + LW) : VLW;

  state_e                            state_q, state_d;
  logic [GW-1:0]                     grp_q, grp_d;
  logic [VLW-1:0]                    vl_q, vl_d;
  logic                              vm_q, vm_d;
  logic [MAX_VL-1:0]                 mask_q, mask_d;
  logic [MICROOP_WIDTH-1:0]          microop_q, microop_d;
  logic [DATA_WIDTH-1:0]             imm_q, imm_d;
  logic                              err_q, err_d;
  logic [VECTOR_LANES*DATA_WIDTH-1:0] wbData_q, wbData_d;
  logic [VECTOR_LANES-1:0]           wbEn_q, wbEn_d;

  logic [VECTOR_LANES-1:0]           laneActive;
  logic [VECTOR_LANES-1:0]           laneMask;
  logic [GW:0]                       grpInc;
  logic                              lastGroup;

  valu_seq_laneen #(
    .VECTOR_LANES (VECTOR_LANES),
    .VLW          (VLW),
    .GW           (GW)
  ) u_laneen (
    .grp_i    (grp_q),
    .vl_i     (vl_q),
    .vm_i     (vm_q),
    .mask_i   (mask_q),
    .active_o (laneActive),
    .mask_o   (laneMask)
  );

  // The group just written back is the last one once (grp+1)*lanes covers vl
  assign grpInc    = {1'b0, grp_q} + (GW+1)'(1);
  assign lastGroup = CW'({grpInc, {LW{1'b0}}}) >= CW'(vl_q);

  // Next-state and datapath capture for the instruction walk
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    vl_d      = vl_q;
    vm_d      = vm_q;
    mask_d    = mask_q;
    microop_d = microop_q;
    imm_d     = imm_q;
    err_d     = err_q;
    wbData_d  = wbData_q;
    wbEn_d    = wbEn_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid_i) begin
          microop_d = issue_microop_i;
          imm_d     = issue_imm_i;
          vm_d      = issue_vm_i;
          mask_d    = issue_mask_i;
          vl_d      = (32'(issue_vl_i) > MAX_VL) ? VLW'(MAX_VL) : issue_vl_i;
          err_d     = 1'b0;
          grp_d     = '0;
          state_d   = (issue_vl_i == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        for (int i = 0; i < VECTOR_LANES; i++) begin
          wbData_d[i*DATA_WIDTH +: DATA_WIDTH] =
            laneActive[i] ? valu_result_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        wbEn_d = laneActive & valu_ready_res_i;
        if (|(laneActive & ~valu_ready_res_i)) begin
          err_d = 1'b1;
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        if (wb_ready_i) begin
          grp_d   = grpInc[GW-1:0];
          state_d = lastGroup ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grp_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      mask_q    <= '0;
      microop_q <= '0;
      imm_q     <= '0;
      err_q     <= 1'b0;
      wbData_q  <= '0;
      wbEn_q    <= '0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      vl_q      <= vl_d;
      vm_q      <= vm_d;
      mask_q    <= mask_d;
      microop_q <= microop_d;
      imm_q     <= imm_d;
      err_q     <= err_d;
      wbData_q  <= wbData_d;
      wbEn_q    <= wbEn_d;
    end
  end

  assign issue_ready_o  = (state_q == ST_IDLE);
  assign rd_req_o       = (state_q == ST_READ);
  assign rd_grp_o       = grp_q;
  assign valu_valid_o   = (state_q == ST_EXEC) ? laneActive : '0;
  assign valu_mask_o    = (state_q == ST_EXEC) ? laneMask : '0;
  assign valu_data_a_o  = rd_data_a_i;
  assign valu_data_b_o  = rd_data_b_i;
  assign valu_imm_o     = imm_q;
  assign valu_microop_o = microop_q;
  assign valu_vl_o      = vl_q;
  assign wb_valid_o     = (state_q == ST_WB);
  assign wb_grp_o       = grp_q;
  assign wb_data_o      = wbData_q;
  assign wb_en_o        = (state_q == ST_WB) ? wbEn_q : '0;
  assign done_o         = (state_q == ST_DONE);
  assign done_err_o     = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_valu_seq.sv
// Scoreboard bench for valu_seq: an element-level reference model predicts
// every exec group, writeback beat and completion; a monitor compares them.
module tb_valu_seq;
  import valu_pkg::*;

  localparam int DW    = 32;
  localparam int LANES = 8;
  localparam int MAXVL = 32 * LANES;
  localparam int VLWT  = VALU_VLW;
  localparam int GWT   = VALU_GW;

  typedef struct {
    int                 grp;
    logic [LANES-1:0]   valid;
    logic [LANES-1:0]   lmask;
    int                 vl;
  } execExp_t;

  typedef struct {
    int                    grp;
    logic [LANES-1:0]      en;
    logic [LANES*DW-1:0]   data;
  } wbExp_t;

  typedef struct {
    logic err;
    int   cycle;
  } doneExp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  issueValid;
  logic                  issue_ready_o;
  logic [4:0]            issueMicroop;
  logic [VLWT-1:0]       issueVl;
  logic                  issueVm;
  logic [MAXVL-1:0]      issueMask;
  logic [DW-1:0]         issueImm;
  logic                  rd_req_o;
  logic [GWT-1:0]        rd_grp_o;
  logic [LANES*DW-1:0]   rdDataA, rdDataB;
  logic [LANES-1:0]      valu_valid_o;
  logic [LANES*DW-1:0]   valu_data_a_o, valu_data_b_o;
  logic [DW-1:0]         valu_imm_o;
  logic [4:0]            valu_microop_o;
  logic [VLWT-1:0]       valu_vl_o;
  logic [LANES-1:0]      valu_mask_o;
  logic [LANES-1:0]      valuReadyRes;
  logic [LANES*DW-1:0]   valuResult;
  logic                  wb_valid_o;
  logic                  wbReady;
  logic [GWT-1:0]        wb_grp_o;
  logic [LANES*DW-1:0]   wb_data_o;
  logic [LANES-1:0]      wb_en_o;
  logic                  done_o, done_err_o;

  logic [DW-1:0]         vrfA [32][LANES];
  logic [DW-1:0]         vrfB [32][LANES];
  logic [LANES-1:0]      killMask;
  int                    wbMode;
  int                    cycleCount = 0;
  int                    acceptCycle;
  int                    vrfGrp;
  int                    checks = 0;
  int                    fails = 0;
  bit                    execPending = 0;
  bit                    readyCheckNext = 0;
  execExp_t              execQ[$];
  wbExp_t                wbQ[$];
  doneExp_t              doneQ[$];
  execExp_t              curExec;
  doneExp_t              curDone;

  valu_seq dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issueValid),
    .issue_ready_o   (issue_ready_o),
    .issue_microop_i (issueMicroop),
    .issue_vl_i      (issueVl),
    .issue_vm_i      (issueVm),
    .issue_mask_i    (issueMask),
    .issue_imm_i     (issueImm),
    .rd_req_o        (rd_req_o),
    .rd_grp_o        (rd_grp_o),
    .rd_data_a_i     (rdDataA),
    .rd_data_b_i     (rdDataB),
    .valu_valid_o    (valu_valid_o),
    .valu_data_a_o   (valu_data_a_o),
    .valu_data_b_o   (valu_data_b_o),
    .valu_imm_o      (valu_imm_o),
    .valu_microop_o  (valu_microop_o),
    .valu_vl_o       (valu_vl_o),
    .valu_mask_o     (valu_mask_o),
    .valu_ready_res_i(valuReadyRes),
    .valu_result_i   (valuResult),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wbReady),
    .wb_grp_o        (wb_grp_o),
    .wb_data_o       (wb_data_o),
    .wb_en_o         (wb_en_o),
    .done_o          (done_o),
    .done_err_o      (done_err_o)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behaviour of one VALU lane for each supported microop
  function automatic logic [DW-1:0] aluOp(input logic [4:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] imm);
    case (op)
      VADD:    return a + b;
      VSUB:    return a - b;
      VAND:    return a & b;
      VOR:     return a | b;
      VXOR:    return a ^ b;
      VSLL:    return a << b[4:0];
      VSRL:    return a >> b[4:0];
      VSRA:    return $signed(a) >>> b[4:0];
      VADDI:   return a + imm;
      VANDI:   return a & imm;
      VORI:    return a | imm;
      VXORI:   return a ^ imm;
      VSLLI:   return a << imm[4:0];
      VSRLI:   return a >> imm[4:0];
      VSRAI:   return $signed(a) >>> imm[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic bit isSupported(input logic [4:0] op);
    return (op inside {VADD, VSUB, VAND, VOR, VXOR, VSLL, VSRL, VSRA,
                       VADDI, VANDI, VORI, VXORI, VSLLI, VSRLI, VSRAI});
  endfunction

  // External VALU lane array: same-cycle result; killed lanes and unknown
  // microops never raise ready; idle lanes return garbage with ready high
  always_comb begin
    valuResult   = '0;
    valuReadyRes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valu_valid_o[i]) begin
        valuResult[i*DW +: DW] = aluOp(valu_microop_o, valu_data_a_o[i*DW +: DW],
                                       valu_data_b_o[i*DW +: DW], valu_imm_o);
        valuReadyRes[i] = isSupported(valu_microop_o) && !killMask[i];
      end else begin
        valuResult[i*DW +: DW] = 32'hDEADBEEF;
        valuReadyRes[i]        = 1'b1;
      end
    end
  end

  // VRF read port: data for the requested group appears one cycle later
  always begin
    @(negedge clk);
    if (rd_req_o === 1'b1) begin
      vrfGrp = int'(rd_grp_o);
      @(posedge clk);
      #1;
      for (int i = 0; i < LANES; i++) begin
        rdDataA[i*DW +: DW] = vrfA[vrfGrp][i];
        rdDataB[i*DW +: DW] = vrfB[vrfGrp][i];
      end
    end
  end

  // Writeback sink: always ready, randomly stalling, or under manual control
  always begin
    @(posedge clk);
    #1;
    if (wbMode == 0) wbReady = 1'b1;
    else if (wbMode == 1) wbReady = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [LANES*DW-1:0] actual,
                             input logic [LANES*DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: got event/timeout expected none at cycle %0d", name, cycleCount);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents exec, wb or done
  always @(negedge clk) begin
    if (rst) begin
      execPending    = 0;
      readyCheckNext = 0;
    end else begin
      if (readyCheckNext) begin
        checkOutput("issue_ready_after_done", issue_ready_o, 1);
        readyCheckNext = 0;
      end
      if (execPending) begin
        if (execQ.size() == 0) reportFail("exec_unexpected");
        else begin
          curExec = execQ.pop_front();
          checkOutput("valu_valid", valu_valid_o, curExec.valid);
          checkOutput("valu_mask", valu_mask_o, curExec.lmask);
          checkOutput("valu_vl", valu_vl_o, curExec.vl);
        end
        execPending = 0;
      end
      if (rd_req_o) begin
        checkOutput("rd_req_no_wb", wb_valid_o, 0);
        if (execQ.size() == 0) reportFail("rd_req_unexpected");
        else checkOutput("rd_grp", rd_grp_o, execQ[0].grp);
        execPending = 1;
      end
      if (wb_valid_o) begin
        if (wbQ.size() == 0) reportFail("wb_unexpected");
        else begin
          checkOutput("wb_grp", wb_grp_o, wbQ[0].grp);
          checkOutput("wb_data", wb_data_o, wbQ[0].data);
          if (wbReady) begin
            checkOutput("wb_en", wb_en_o, wbQ[0].en);
            void'(wbQ.pop_front());
          end
        end
      end
      if (done_o) begin
        if (doneQ.size() == 0) reportFail("done_unexpected");
        else begin
          curDone = doneQ.pop_front();
          checkOutput("done_err", done_err_o, curDone.err);
          if (curDone.cycle >= 0) checkOutput("done_cycle", cycleCount, curDone.cycle);
        end
        readyCheckNext = 1;
      end
    end
  end

  // Reference model: element-by-element prediction of one instruction
  task automatic pushExpect(input logic [4:0] op, input int vl, input logic vm,
                            input logic [MAXVL-1:0] mask, input logic [DW-1:0] imm);
    int       effVl = (vl > MAXVL) ? MAXVL : vl;
    int       nGrp  = (effVl + LANES - 1) / LANES;
    logic     err   = 1'b0;
    execExp_t ex;
    wbExp_t   wb;
    doneExp_t dn;
    for (int g = 0; g < nGrp; g++) begin
      ex.grp = g; ex.valid = '0; ex.lmask = '0; ex.vl = effVl;
      wb.grp = g; wb.en = '0; wb.data = '0;
      for (int i = 0; i < LANES; i++) begin
        int  e  = g * LANES + i;
        bit  on = vm || mask[e];
        bit  rdy;
        ex.lmask[i] = on;
        if (e < effVl && on) begin
          ex.valid[i] = 1'b1;
          wb.data[i*DW +: DW] = aluOp(op, vrfA[g][i], vrfB[g][i], imm);
          rdy = isSupported(op) && !killMask[i];
          wb.en[i] = rdy;
          if (!rdy) err = 1'b1;
        end
      end
      execQ.push_back(ex);
      wbQ.push_back(wb);
    end
    dn.err   = err;
    dn.cycle = (wbMode == 0) ? acceptCycle + 3 * nGrp + 1 : -1;
    doneQ.push_back(dn);
  endtask

  task automatic waitIdle();
    bit seen = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (issue_ready_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) reportFail("idle_timeout");
  endtask

  task automatic fillVrf(input bit ramp);
    for (int g = 0; g < 32; g++) begin
      for (int i = 0; i < LANES; i++) begin
        vrfA[g][i] = ramp ? DW'(i) : $urandom;
        vrfB[g][i] = ramp ? 32'd10 : $urandom;
      end
    end
  endtask

  // Offer one instruction, record its acceptance and queue its prediction
  task automatic applyStimulus(input logic [4:0] op, input int vl, input logic vm,
                               input logic [MAXVL-1:0] mask, input logic [DW-1:0] imm,
                               input logic [LANES-1:0] kill);
    waitIdle();
    @(posedge clk);
    #1;
    killMask     = kill;
    issueMicroop = op;
    issueVl      = VLWT'(vl);
    issueVm      = vm;
    issueMask    = mask;
    issueImm     = imm;
    issueValid   = 1'b1;
    @(negedge clk);
    checkOutput("issue_ready_accept", issue_ready_o, 1);
    acceptCycle = cycleCount;
    pushExpect(op, vl, vm, mask, imm);
    @(posedge clk);
    #1;
    issueValid = 1'b0;
    @(negedge clk);
    checkOutput("issue_ready_busy", issue_ready_o, 0);
  endtask

  logic [4:0] opList [16] = '{VADD, VSUB, VAND, VOR, VXOR, VSLL, VSRL, VSRA,
                              VADDI, VANDI, VORI, VXORI, VSLLI, VSRLI, VSRAI, 5'b01111};

  initial begin
    bit quiet;
    rst = 1'b1; issueValid = 1'b0; issueMicroop = '0; issueVl = '0; issueVm = 1'b0;
    issueMask = '0; issueImm = '0; rdDataA = '0; rdDataB = '0; killMask = '0;
    wbMode = 0; wbReady = 1'b1;
    fillVrf(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_issue_ready", issue_ready_o, 1);
    checkOutput("reset_rd_req", rd_req_o, 0);
    checkOutput("reset_wb_valid", wb_valid_o, 0);
    checkOutput("reset_done", {done_o, done_err_o}, 0);
    checkOutput("reset_valu_valid", valu_valid_o, 0);
    checkOutput("reset_wb_en_data", {wb_en_o, wb_data_o}, 0);
    checkOutput("reset_valu_vl_imm", {valu_vl_o, valu_imm_o, valu_microop_o}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed: VADD vl=8 ramp operands");
    waitIdle(); fillVrf(1'b1);
    applyStimulus(VADD, 8, 1'b1, '0, '0, '0);

    $display("[TB] directed: VSUB vl=11 two groups");
    waitIdle(); fillVrf(1'b0);
    applyStimulus(VSUB, 11, 1'b1, '0, '0, '0);

    $display("[TB] directed: VAND masked 0xA5");
    waitIdle(); fillVrf(1'b0);
    applyStimulus(VAND, 8, 1'b0, MAXVL'(8'hA5), '0, '0);

    $display("[TB] directed: writeback stall");
    waitIdle(); fillVrf(1'b0);
    wbMode = 2; wbReady = 1'b0;
    applyStimulus(VADD, 16, 1'b1, '0, '0, '0);
    @(negedge clk);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("stall_wb_valid_held", wb_valid_o, 1);
      checkOutput("stall_no_rd_req", rd_req_o, 0);
    end
    @(posedge clk);
    #1 wbReady = 1'b1;
    @(negedge clk);
    checkOutput("stall_handshake_no_rd_req", rd_req_o, 0);
    @(negedge clk);
    checkOutput("stall_next_read_c7", rd_req_o, 1);
    wbMode = 0;

    $display("[TB] directed: unsupported microop");
    waitIdle(); fillVrf(1'b0);
    applyStimulus(5'b01111, 8, 1'b1, '0, '0, '0);

    $display("[TB] directed: vl=0");
    applyStimulus(VADD, 0, 1'b1, '0, '0, '0);

    $display("[TB] directed: vl clamp and full length");
    waitIdle(); fillVrf(1'b0);
    applyStimulus(VXOR, 300, 1'b1, '0, '0, '0);
    waitIdle(); fillVrf(1'b0);
    applyStimulus(VSRAI, 256, 1'b0, {8{32'($urandom)}}, 32'd7, '0);
    waitIdle(); fillVrf(1'b0);
    applyStimulus(VSLL, 255, 1'b1, '0, '0, '0);

    $display("[TB] directed: lanes refusing results");
    waitIdle(); fillVrf(1'b0);
    applyStimulus(VOR, 13, 1'b1, '0, '0, 8'h24);

    $display("[TB] directed: reset during EXEC");
    waitIdle(); fillVrf(1'b0);
    applyStimulus(VADD, 16, 1'b1, '0, '0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_exec_lanes", valu_valid_o, 8'hFF);
    @(posedge clk);
    #1 rst = 1'b0;
    execQ.delete(); wbQ.delete(); doneQ.delete();
    @(negedge clk);
    checkOutput("rst_abort_ready", issue_ready_o, 1);
    checkOutput("rst_abort_no_wb", wb_valid_o, 0);
    quiet = 1;
    repeat (6) begin
      @(negedge clk);
      if (rd_req_o || wb_valid_o || done_o) quiet = 0;
    end
    checkOutput("rst_abort_quiet", quiet, 1);

    $display("[TB] random phase");
    wbMode = 1;
    for (int n = 0; n < 30; n++) begin
      int                 sel = $urandom_range(0, 9);
      int                 vl;
      logic [MAXVL-1:0]   mask;
      logic [LANES-1:0]   kill;
      vl = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(256, 511) : $urandom_range(1, 64);
      for (int w = 0; w < 8; w++) mask[w*32 +: 32] = $urandom;
      kill = ($urandom_range(0, 4) == 0) ? LANES'($urandom) : '0;
      waitIdle(); fillVrf(1'b0);
      applyStimulus(opList[$urandom_range(0, 15)], vl, 1'($urandom_range(0, 1)),
                    mask, $urandom, kill);
    end

    wbMode = 0;
    waitIdle();
    repeat (5) @(negedge clk);
    checkOutput("exec_queue_drained", execQ.size(), 0);
    checkOutput("wb_queue_drained", wbQ.size(), 0);
    checkOutput("done_queue_drained", doneQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
